// File: rtl/sprite_dma.sv
// Sprite DMA: snoops a CPU write to TRIGGER_ADDR, halts the CPU and copies one
// 256-byte page to TARGET_ADDR. Optional read-alignment cycle under SPRITE_DMA_ALIGN_EN.
module sprite_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] TARGET_ADDR  = 16'h2004
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cycle_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_odata,
    input  logic        cpu_rw,
    input  logic [7:0]  idata,
    output logic        cpu_rdy,
    output logic        bus_sel,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_odata,
    output logic        dma_rw,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_FINISH
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] page, index, data;
    logic       trig;
    logic       go_align;

    assign trig = cycle_en && !cpu_rw && (cpu_addr == TRIGGER_ADDR);

`ifdef SPRITE_DMA_ALIGN_EN
    // Free-running bus-cycle parity; an odd cycle needs one dummy read first.
    logic parity;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      parity <= 1'b0;
        else if (cycle_en) parity <= ~parity;
    end
    assign go_align = parity;
`else
    assign go_align = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (trig) state_nxt = S_HALT;
            S_HALT:   if (cycle_en && cpu_rw) state_nxt = go_align ? S_ALIGN : S_READ;
            S_ALIGN:  if (cycle_en) state_nxt = S_READ;
            S_READ:   if (cycle_en) state_nxt = S_WRITE;
            S_WRITE:  if (cycle_en) state_nxt = (index == 8'hFF) ? S_FINISH : S_READ;
            S_FINISH: if (cycle_en) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            page  <= 8'h00;
            index <= 8'h00;
            data  <= 8'h00;
        end else if (cycle_en) begin
            case (state)
                S_IDLE: if (trig) begin
                    page  <= cpu_odata;
                    index <= 8'h00;
                end
                S_READ:  data <= idata;
                S_WRITE: if (index != 8'hFF) index <= index + 8'h01;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_sel   = 1'b0;
        cpu_rdy   = 1'b1;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        dma_rw    = 1'b1;
        dma_addr  = 16'h0000;
        dma_odata = 8'h00;
        case (state)
            S_HALT: cpu_rdy = 1'b0;
            S_ALIGN, S_READ: begin
                bus_sel  = 1'b1;
                cpu_rdy  = 1'b0;
                dma_addr = {page, index};
            end
            S_WRITE: begin
                bus_sel   = 1'b1;
                cpu_rdy   = 1'b0;
                dma_addr  = TARGET_ADDR;
                dma_odata = data;
                dma_rw    = 1'b0;
            end
            // done coincides with the cycle_en that retires FINISH, so it is one clk wide.
            S_FINISH: done = cycle_en;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sprite_dma.sv
// Directed bench for sprite_dma: full page copies, halt-wait, alignment,
// ignored re-trigger, mid-transfer reset and the last-byte write.
module tb_sprite_dma;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cycle_en = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_odata = 8'h00;
    logic        cpu_rw = 1'b1;
    logic [7:0]  idata;
    logic        cpu_rdy, bus_sel, dma_rw, busy, done;
    logic [15:0] dma_addr;
    logic [7:0]  dma_odata;

    int nerr = 0;
    int nchk = 0;
    int ncyc = 0;
    int ndone = 0;

    sprite_dma dut (
        .clk(clk), .reset_n(reset_n), .cycle_en(cycle_en),
        .cpu_addr(cpu_addr), .cpu_odata(cpu_odata), .cpu_rw(cpu_rw),
        .idata(idata), .cpu_rdy(cpu_rdy), .bus_sel(bus_sel),
        .dma_addr(dma_addr), .dma_odata(dma_odata), .dma_rw(dma_rw),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [15:0] a);
        mem = (a[7:0] == 8'hFF) ? 8'hc3 : (a[7:0] ^ 8'h5a);
    endfunction

    assign idata = mem(dma_addr);

    always @(posedge clk) if (done) ndone++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [15:0] a, input logic [7:0] d);
        cpu_rw = rw; cpu_addr = a; cpu_odata = d; cycle_en = 1'b1;
        ncyc++;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_en = 1'b0;
        @(negedge clk);
    endtask

    // pg: page byte, nw: CPU writes while halted, want_par: parity on the halting read,
    // ign_at: index whose WRITE cycle sees a re-trigger, rst_at: index whose READ gets reset.
    task automatic xfer(input logic [7:0] pg, input int nw, input bit want_par,
                        input int ign_at, input int rst_at);
        bit exp_align;
        int ndma, d0;
        // parity on the halting read = parity of cycles issued before it
        if (((ncyc + 1 + nw) & 1) != int'(want_par)) begin
            drive(1'b1, 16'h8000, 8'h00);
            chk("idle_busy", busy, 1'b0);
            tick();
        end
`ifdef SPRITE_DMA_ALIGN_EN
        exp_align = want_par;
`else
        exp_align = 1'b0;
`endif
        drive(1'b0, 16'h4014, pg);
        chk("trig_busy_pre", busy, 1'b0);
        tick();
        for (int w = 0; w < nw; w++) begin
            drive(1'b0, 16'h0300, 8'h11);
            chk("halt_wr_rdy", cpu_rdy, 1'b0);
            chk("halt_wr_sel", bus_sel, 1'b0);
            chk("halt_wr_busy", busy, 1'b1);
            tick();
        end
        drive(1'b1, 16'h0000, 8'h00);
        chk("halt_rd_rdy", cpu_rdy, 1'b0);
        chk("halt_rd_sel", bus_sel, 1'b0);
        tick();
        ndma = 0;
        if (exp_align) begin
            drive(1'b1, 16'h0000, 8'h00);
            chk("align_addr", dma_addr, {pg, 8'h00});
            chk("align_rw", dma_rw, 1'b1);
            chk("align_sel", bus_sel, 1'b1);
            if (bus_sel) ndma++;
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 16'h0000, 8'h00);
            chk("rd_addr", dma_addr, {pg, 8'(i)});
            chk("rd_rw", dma_rw, 1'b1);
            chk("rd_sel", bus_sel, 1'b1);
            chk("rd_rdy", cpu_rdy, 1'b0);
            if (bus_sel) ndma++;
            if (i == rst_at) begin
                d0 = ndone;
                #2 reset_n = 1'b0;
                #1;
                chk("rst_sel", bus_sel, 1'b0);
                chk("rst_rdy", cpu_rdy, 1'b1);
                chk("rst_busy", busy, 1'b0);
                chk("rst_addr", dma_addr, 16'h0000);
                chk("rst_rw", dma_rw, 1'b1);
                tick();
                reset_n = 1'b1;
                ncyc = 0;
                chk("rst_nodone", ndone, d0);
                chk("rst_idle_busy", busy, 1'b0);
                return;
            end
            tick();
            if (i == ign_at) drive(1'b0, 16'h4014, 8'h05);
            else             drive(1'b1, 16'h0000, 8'h00);
            chk("wr_addr", dma_addr, 16'h2004);
            chk("wr_rw", dma_rw, 1'b0);
            chk("wr_data", dma_odata, mem({pg, 8'(i)}));
            if (i == 255) chk("last_data_c3", dma_odata, 8'hc3);
            if (i == ign_at) chk("ign_busy", busy, 1'b1);
            if (bus_sel) ndma++;
            tick();
        end
        chk("dma_cycles", ndma, 512 + int'(exp_align));
        drive(1'b1, 16'h0000, 8'h00);
        chk("fin_rdy", cpu_rdy, 1'b1);
        chk("fin_sel", bus_sel, 1'b0);
        chk("fin_done", done, 1'b1);
        chk("fin_busy", busy, 1'b1);
        d0 = ndone;
        tick();
        chk("done_once", ndone, d0 + 1);
        chk("end_busy", busy, 1'b0);
        chk("end_done", done, 1'b0);
        chk("end_rdy", cpu_rdy, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_rdy0", cpu_rdy, 1'b1);
        chk("rst_sel0", bus_sel, 1'b0);
        chk("rst_busy0", busy, 1'b0);
        chk("rst_done0", done, 1'b0);
        chk("rst_rw0", dma_rw, 1'b1);
        chk("rst_addr0", dma_addr, 16'h0000);
        chk("rst_odata0", dma_odata, 8'h00);
        reset_n = 1'b1;
        ncyc = 0;
        @(negedge clk);

        xfer(8'h02, 0, 1'b0, -1, -1);   // basic copy of page 02, no alignment
        xfer(8'h03, 2, 1'b0, -1, -1);   // two CPU writes while halted
        xfer(8'h02, 0, 1'b1, -1, -1);   // odd parity: dummy read when alignment enabled
        xfer(8'h02, 0, 1'b0, 8'h40, -1); // re-trigger with 05 ignored
        xfer(8'h02, 0, 1'b0, -1, 8'h80); // reset mid-transfer

        drive(1'b1, 16'h8000, 8'h00);
        chk("post_busy", busy, 1'b0);
        chk("post_sel", bus_sel, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sprite_dma.md
SPRITE_DMA -- requirements
Module: sprite_dma

Interface
REQ-001 Parameter TRIGGER_ADDR, default 16'h4014, is the CPU write address that starts a transfer.
REQ-002 Parameter TARGET_ADDR, default 16'h2004, is the fixed destination address of every DMA write.
REQ-003 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port cycle_en, input, 1: one-clk pulse marking the end of each CPU bus cycle; FSM advances only on clk edges where cycle_en=1.
REQ-006 Port cpu_addr, input, 16: CPU address bus, snooped.
REQ-007 Port cpu_odata, input, 8: CPU write data, snooped.
REQ-008 Port cpu_rw, input, 1: CPU read/write strobe (1=read, 0=write).
REQ-009 Port idata, input, 8: memory read data returned to the bus master.
REQ-010 Port cpu_rdy, output, 1: 0 halts the CPU.
REQ-011 Port bus_sel, output, 1: 1 gives the bus to DMA (external mux selects dma_* over cpu_*).
REQ-012 Port dma_addr, output, 16: DMA address.
REQ-013 Port dma_odata, output, 8: DMA write data.
REQ-014 Port dma_rw, output, 1: DMA read/write (1=read).
REQ-015 Port busy, output, 1: high from trigger capture until return to IDLE.
REQ-016 Port done, output, 1: one-clk pulse on transfer completion.

Function
REQ-017 The FSM SHALL have the states IDLE, HALT, ALIGN, READ, WRITE and FINISH.
REQ-018 IDLE: on cycle_en with cpu_rw=0 and cpu_addr=TRIGGER_ADDR, the block SHALL latch page=cpu_odata, clear index to 0, set busy=1 and go to HALT.
REQ-019 HALT: cpu_rdy=0; on the first cycle_en with cpu_rw=1 (the CPU stalls only on reads), bus_sel SHALL go to 1 and the FSM SHALL go to ALIGN if parity=1, else to READ.
REQ-020 parity SHALL be a 1-bit flag toggled on every cycle_en from reset, independent of state.
REQ-021 ALIGN: the block SHALL drive one dummy read cycle (dma_rw=1, dma_addr={page,index}) and then go to READ.
REQ-022 READ: dma_addr={page,index}, dma_rw=1; on cycle_en the block SHALL latch idata into its data register and go to WRITE.
REQ-023 WRITE: dma_addr=TARGET_ADDR, dma_odata=data register, dma_rw=0; on cycle_en, if index=8'hFF the block SHALL go to FINISH, else it SHALL increment index and go to READ.
REQ-024 FINISH: bus_sel=0 and cpu_rdy=1; the block SHALL pulse done for 1 clk, clear busy and go to IDLE on the next cycle_en.
REQ-025 index SHALL be 8-bit; there is no carry into page, and a transfer is always exactly 256 bytes.
REQ-026 Trigger writes while busy=1 SHALL be ignored, with no restart and no re-latch of page.
REQ-027 While bus_sel=0: dma_rw=1, dma_addr=16'h0000, dma_odata=8'h00.
REQ-028 Latency: CPU cycles from trigger to FINISH = 1 + halt-wait + align (0/1) + 512.

Reset
REQ-029 On reset_n=0 the block SHALL immediately enter IDLE with cpu_rdy=1, bus_sel=0, busy=0, done=0, dma_rw=1, dma_addr=0, dma_odata=0, page=0, index=0 and parity=0.
REQ-030 A reset mid-transfer SHALL abort the transfer, release the bus and raise no done pulse.

Configuration
REQ-031 The macro SPRITE_DMA_ALIGN_EN SHALL control alignment: when defined, the ALIGN state and parity behaviour apply as above; when undefined, HALT SHALL always proceed directly to READ, the ALIGN state is unreachable and the transfer always takes 512 DMA cycles.

Verification
REQ-032 The bench SHALL check: cpu writes 8'h02 to 4014, then next cycle is a read with parity=0 -> 256 reads 0200..02FF, each followed by a write of the same byte to 2004; done pulses once; cpu_rdy returns to 1.
REQ-033 The bench SHALL check: trigger followed by two CPU write cycles before a read -> cpu_rdy=0 while bus_sel stays 0 through both writes; bus_sel=1 on the first read.
REQ-034 The bench SHALL check: trigger with parity=1 and SPRITE_DMA_ALIGN_EN defined -> exactly one extra dummy read at 0200 before the first real read; total 513 DMA cycles.
REQ-035 The bench SHALL check: second write of 8'h05 to 4014 at index 8'h40 -> ignored; dma_addr continues 0241; page stays 02.
REQ-036 The bench SHALL check: reset_n pulsed low at index 8'h80 -> bus_sel=0, cpu_rdy=1, busy=0 asynchronously; no done pulse.
REQ-037 The bench SHALL check: memory at 02FF=8'hc3 -> final WRITE drives dma_addr=2004, dma_odata=c3, dma_rw=0, then FINISH.
